// File: rtl/pulse_symbol_sequencer_pkg.sv
// pulse_tx_pkg: shared state encoding, symbol layout and default widths for the pulse symbol sequencer
package pulse_tx_pkg;
  localparam int DEF_SYMBOL_COUNT = 8;
  localparam int DEF_TIMER_WIDTH = 8;
  localparam int DEF_PRESCALER_WIDTH = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_e;
  typedef struct packed {
    logic level;
    logic [DEF_TIMER_WIDTH-1:0] duration;
  } symbol_t;
endpackage

// File: rtl/pulse_symbol_sequencer_if.sv
// pulse_symbol_sequencer_if: write and fetch ports of the symbol table
interface pulse_symbol_sequencer_if
  import pulse_tx_pkg::*;
#(
  parameter int AW = $clog2(DEF_SYMBOL_COUNT),
  parameter int DW = DEF_TIMER_WIDTH + 1
) ();
  logic wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data);
  modport slave (input wr_en, wr_addr, wr_data, rd_addr, output rd_data);
endinterface

// File: rtl/pulse_symbol_sequencer_mem.sv
// symbol_mem: register file of {level, duration} slots, one write port and a combinational fetch port
module symbol_mem
  import pulse_tx_pkg::*;
#(
  parameter int SYMBOL_COUNT = DEF_SYMBOL_COUNT,
  parameter int TIMER_WIDTH = DEF_TIMER_WIDTH
) (
  input logic clk,
  input logic sys_rst_n,
  pulse_symbol_sequencer_if.slave mem
);
  logic [TIMER_WIDTH:0] slot [SYMBOL_COUNT];
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) for (int i = 0; i < SYMBOL_COUNT; i++) slot[i] <= '0;
    else if (mem.wr_en) slot[mem.wr_addr] <= mem.wr_data;
  assign mem.rd_data = slot[mem.rd_addr];
endmodule

// File: rtl/pulse_symbol_sequencer.sv
// pulse_symbol_sequencer: plays a table of {level, duration} symbols through an external countdown timer
module pulse_symbol_sequencer
  import pulse_tx_pkg::*;
#(
  parameter int SYMBOL_COUNT = DEF_SYMBOL_COUNT,
  parameter int TIMER_WIDTH = DEF_TIMER_WIDTH,
  parameter int PRESCALER_WIDTH = DEF_PRESCALER_WIDTH
) (
  input  logic clk,
  input  logic sys_rst_n,
  input  logic start,
  input  logic stop,
  input  logic wr_en,
  input  logic [$clog2(SYMBOL_COUNT)-1:0] wr_addr,
  input  logic [TIMER_WIDTH:0] wr_data,
  input  logic [$clog2(PRESCALER_WIDTH)-1:0] prescaler_cfg,
  input  logic [$clog2(SYMBOL_COUNT):0] symbol_count_cfg,
  input  logic [7:0] loop_count_cfg,
  input  logic idle_level,
  input  logic request_data,
  input  logic pulse_out,
  output logic timer_en,
  output logic [$clog2(PRESCALER_WIDTH)-1:0] prescaler,
  output logic [TIMER_WIDTH-1:0] duration,
  output logic pin_out,
  output logic busy,
  output logic done
);
  localparam int AW = $clog2(SYMBOL_COUNT);
  localparam logic [AW:0] NSYM = (AW + 1)'(SYMBOL_COUNT);
  state_e state;
  logic [AW-1:0] index, nidx;
  logic [AW:0] cnt, cnt_cfg;
  logic [7:0] loops_left;
  logic infinite, last_pending, next_level, wrap, is_last;
  pulse_symbol_sequencer_if #(.AW(AW), .DW(TIMER_WIDTH + 1)) mem ();
  assign mem.wr_en = wr_en;
  assign mem.wr_addr = wr_addr;
  assign mem.wr_data = wr_data;
  assign mem.rd_addr = state == RUN ? nidx : '0;
  symbol_mem #(.SYMBOL_COUNT(SYMBOL_COUNT), .TIMER_WIDTH(TIMER_WIDTH)) u_mem (
    .clk(clk), .sys_rst_n(sys_rst_n), .mem(mem)
  );
  assign cnt_cfg = (symbol_count_cfg == '0 || symbol_count_cfg > NSYM) ? NSYM : symbol_count_cfg;
  assign wrap = {1'b0, index} == cnt - 1'b1;
  assign nidx = wrap ? '0 : index + 1'b1;
  assign is_last = wrap && !infinite && loops_left == 8'd1;
  assign busy = state != IDLE;
  // slot 0 is latched on start so LOAD already presents it to the timer
  always_ff @(posedge clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      timer_en <= 1'b0;
      done <= 1'b0;
      pin_out <= 1'b0;
      duration <= '0;
      prescaler <= '0;
      index <= '0;
      cnt <= '0;
      loops_left <= '0;
      infinite <= 1'b0;
      last_pending <= 1'b0;
      next_level <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        pin_out <= idle_level;
        if (start) begin
          state <= LOAD;
          duration <= mem.rd_data[TIMER_WIDTH-1:0];
          next_level <= mem.rd_data[TIMER_WIDTH];
          prescaler <= prescaler_cfg;
          cnt <= cnt_cfg;
          loops_left <= loop_count_cfg;
          infinite <= loop_count_cfg == 8'd0;
          index <= '0;
          last_pending <= 1'b0;
        end
      end else if (stop) begin
        state <= IDLE;
        timer_en <= 1'b0;
        pin_out <= idle_level;
        last_pending <= 1'b0;
      end else if (state == LOAD) begin
        state <= RUN;
        timer_en <= 1'b1;
        pin_out <= next_level;
      end else begin
        if (pulse_out && last_pending) begin
          state <= IDLE;
          timer_en <= 1'b0;
          pin_out <= idle_level;
          done <= 1'b1;
          last_pending <= 1'b0;
        end else if (pulse_out) pin_out <= next_level;
        if (request_data && !last_pending) begin
          duration <= mem.rd_data[TIMER_WIDTH-1:0];
          next_level <= mem.rd_data[TIMER_WIDTH];
          index <= nidx;
          if (wrap && !infinite) loops_left <= loops_left - 8'd1;
          if (is_last) last_pending <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_pulse_symbol_sequencer.sv
// tb_pulse_symbol_sequencer: directed checks of the sequencer driving a behavioural countdown timer
module tb_pulse_symbol_sequencer;
  import pulse_tx_pkg::*;
  logic clk = 0, sys_rst_n = 0, start = 0, stop = 0, idle_level = 0;
  logic [3:0] prescaler_cfg = 0, symbol_count_cfg = 0;
  logic [7:0] loop_count_cfg = 0;
  logic request_data, pulse_out, timer_en, pin_out, busy, done;
  logic [3:0] prescaler;
  logic [7:0] duration;
  int checks = 0, failures = 0;
  logic mon = 0, running = 0;
  int rem = 0, cyc = 0, en_cyc = 0, hi_cyc = 0, npulse = 0, ndone = 0;
  int last_pulse = -1, done_cyc = -2, ld_dur = -1, ld_en = -1, iters = 0;

  pulse_symbol_sequencer_if #(.AW(3), .DW($bits(symbol_t))) wr ();
  assign wr.rd_addr = '0;
  assign wr.rd_data = '0;

  pulse_symbol_sequencer dut (
    .clk(clk), .sys_rst_n(sys_rst_n), .start(start), .stop(stop),
    .wr_en(wr.wr_en), .wr_addr(wr.wr_addr), .wr_data(wr.wr_data),
    .prescaler_cfg(prescaler_cfg), .symbol_count_cfg(symbol_count_cfg),
    .loop_count_cfg(loop_count_cfg), .idle_level(idle_level),
    .request_data(request_data), .pulse_out(pulse_out),
    .timer_en(timer_en), .prescaler(prescaler), .duration(duration),
    .pin_out(pin_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // timer: each symbol lasts (duration+2)<<prescaler cycles, asks for data one cycle before it ends
  assign request_data = timer_en && running && rem == 1;
  assign pulse_out = timer_en && running && rem == 0;
  always @(posedge clk)
    if (!timer_en) running <= 1'b0;
    else if (!running) begin
      running <= 1'b1;
      rem <= ((int'(duration) + 2) << prescaler) - 2;
    end else if (rem == 0) rem <= ((int'(duration) + 2) << prescaler) - 1;
    else rem <= rem - 1;

  always @(negedge clk)
    if (mon) begin
      cyc <= cyc + 1;
      if (timer_en) en_cyc <= en_cyc + 1;
      if (timer_en && pin_out) hi_cyc <= hi_cyc + 1;
      if (pulse_out) begin npulse <= npulse + 1; last_pulse <= cyc; end
      if (done) begin ndone <= ndone + 1; done_cyc <= cyc; end
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic symbol_t sym(input logic l, input int d);
    sym.level = l;
    sym.duration = d[7:0];
  endfunction

  task automatic set_slot(input int a, input symbol_t s);
    @(negedge clk);
    wr.wr_en = 1; wr.wr_addr = a[2:0]; wr.wr_data = s;
    @(negedge clk);
    wr.wr_en = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic run(input string tag, input int poke, input symbol_t poke_sym);
    en_cyc = 0; hi_cyc = 0; npulse = 0; ndone = 0; last_pulse = -1; done_cyc = -2;
    mon = 1;
    pulse_start();
    iters = 0;
    while (busy && iters < 400) begin
      if (iters == 0) begin ld_dur = int'(duration); ld_en = int'(timer_en); end
      start = iters == poke; wr.wr_en = iters == poke; wr.wr_addr = 3'd1; wr.wr_data = poke_sym;
      @(negedge clk);
      iters++;
    end
    start = 0; wr.wr_en = 0;
    @(negedge clk);
    mon = 0;
    check({tag, ".finish_in_budget"}, iters < 400, 1);
  endtask

  task automatic expect_run(input string tag, input int en, input int hi, input int np);
    check({tag, ".enabled_cycles"}, en_cyc, en);
    check({tag, ".high_cycles"}, hi_cyc, hi);
    check({tag, ".pulse_outs"}, npulse, np);
    check({tag, ".done_pulses"}, ndone, 1);
    check({tag, ".done_after_last_pulse"}, done_cyc, last_pulse + 1);
    check({tag, ".idle_after"}, {busy, timer_en, pin_out}, {2'b00, idle_level});
  endtask

  initial begin
    wr.wr_en = 0; wr.wr_addr = 0; wr.wr_data = 0;
    repeat (3) @(negedge clk);
    check("rst.timer_en", timer_en, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pin_out", pin_out, 0);
    check("rst.duration", duration, 0);
    check("rst.prescaler", prescaler, 0);
    sys_rst_n = 1;

    @(negedge clk) idle_level = 1;
    #1 check("idle.latency", pin_out, 0);
    @(negedge clk) check("idle.follow_hi", pin_out, 1);
    idle_level = 0;
    @(negedge clk) check("idle.follow_lo", pin_out, 0);

    set_slot(0, sym(1, 3)); set_slot(1, sym(0, 5));
    prescaler_cfg = 0; symbol_count_cfg = 2; loop_count_cfg = 1;
    run("basic", -1, sym(0, 0));
    check("basic.load_duration", ld_dur, 3);
    check("basic.load_timer_en", ld_en, 0);
    expect_run("basic", 12, 5, 2);

    prescaler_cfg = 2;
    run("presc2", -1, sym(0, 0));
    expect_run("presc2", 48, 20, 2);

    set_slot(0, sym(1, 2)); set_slot(1, sym(0, 3)); set_slot(2, sym(1, 4));
    prescaler_cfg = 0; symbol_count_cfg = 3; loop_count_cfg = 3;
    run("loops3", -1, sym(0, 0));
    expect_run("loops3", 45, 30, 9);

    for (int i = 0; i < 8; i++) set_slot(i, sym(i % 2 == 0, 1));
    symbol_count_cfg = 0; loop_count_cfg = 1;
    run("count0", -1, sym(0, 0));
    expect_run("count0", 24, 12, 8);
    symbol_count_cfg = 12;
    run("count12", -1, sym(0, 0));
    expect_run("count12", 24, 12, 8);

    set_slot(0, sym(1, 6)); set_slot(1, sym(0, 3));
    symbol_count_cfg = 2; loop_count_cfg = 1;
    run("rewrite", 3, sym(0, 7));
    expect_run("rewrite", 17, 8, 2);

    set_slot(0, sym(0, 3)); set_slot(1, sym(0, 5));
    loop_count_cfg = 0; idle_level = 1;
    @(negedge clk);
    pulse_start();
    repeat (20) @(negedge clk);
    check("stop.busy_before", busy, 1);
    check("stop.pin_before", pin_out, 0);
    iters = 0;
    while (!pulse_out && iters < 50) begin @(negedge clk); iters++; end
    check("stop.pulse_seen", iters < 50, 1);
    stop = 1;
    @(negedge clk) stop = 0;
    check("stop.timer_en", timer_en, 0);
    check("stop.pin_out", pin_out, 1);
    check("stop.busy", busy, 0);
    check("stop.done", done, 0);
    repeat (3) @(negedge clk);
    check("stop.done_later", done, 0);
    check("stop.still_idle", busy, 0);

    idle_level = 0;
    set_slot(0, sym(1, 3)); set_slot(1, sym(0, 5));
    prescaler_cfg = 2; loop_count_cfg = 1;
    @(negedge clk);
    pulse_start();
    repeat (6) @(negedge clk);
    check("arst.pin_before", pin_out, 1);
    check("arst.prescaler_before", prescaler, 2);
    sys_rst_n = 0;
    #1;
    check("arst.timer_en", timer_en, 0);
    check("arst.busy", busy, 0);
    check("arst.pin_out", pin_out, 0);
    check("arst.duration", duration, 0);
    check("arst.prescaler", prescaler, 0);
    check("arst.done", done, 0);
    @(negedge clk) sys_rst_n = 1;
    set_slot(0, sym(1, 4)); set_slot(1, sym(0, 2));
    prescaler_cfg = 0;
    run("after_rst", -1, sym(0, 0));
    expect_run("after_rst", 10, 6, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
